// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state and transfer direction.
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    typedef enum logic {
        Read  = 1'b0,
        Write = 1'b1
    } e_rw;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles and flags the cycle in which the wait limit is reached.
module apb_timeout_ctr #(
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Limit == 0) ? 1 : $clog2(Limit + 1);
    localparam logic [CntW-1:0] LimitC = CntW'(Limit);
    localparam logic [CntW:0]   LimitX = (CntW + 1)'(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW:0]   cnt_next_ext;

    // Next count: clear wins, otherwise increment while enabled and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LimitC)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Expired when the current wait cycle (count so far plus this one) reaches the limit.
    always_comb begin
        cnt_next_ext = {1'b0, cnt_q} + (CntW + 1)'(1);
        expired_o    = (Limit != 0) && enable_i && !clear_i && (cnt_next_ext >= LimitX);
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: command in, one APB transfer, one-cycle response pulse.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int unsigned addrWidth     = 32,
    parameter int unsigned dataWidth     = 8,
    parameter int unsigned timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [addrWidth-1:0] paddr,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    apb_state_e           state_q, state_d;
    logic [addrWidth-1:0] paddr_q, paddr_d;
    e_rw                  rw_q, rw_d;
    logic [dataWidth-1:0] pwdata_q, pwdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 to_clear, to_enable, to_expired;

    // Wait cycles only count while in ACCESS with the slave stalling.
    assign to_clear  = (state_q != StAccess);
    assign to_enable = (state_q == StAccess) && !pready;

    apb_timeout_ctr #(
        .Limit(timeoutCycles)
    ) u_timeout_ctr (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (to_clear),
        .enable_i (to_enable),
        .expired_o(to_expired)
    );

    // Next-state and APB control decode; pready is checked before the timeout.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        rw_d        = rw_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready   = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    rw_d     = e_rw'(cmd_write);
                    pwdata_d = cmd_wdata;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                psel    = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (rw_q == Read) ? prdata : '0;
                    rsp_err_d   = pslverr;
                    state_d     = StIdle;
                end else if (to_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, APB address/data and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            rw_q        <= Read;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            rw_q        <= rw_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = (rw_q == Write);
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: random commands, behavioural slave, response monitor.
module tb_apb_initiator;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    apb_initiator #(
        .addrWidth    (AW),
        .dataWidth    (DW),
        .timeoutCycles(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            acc;
    } exp_t;

    typedef struct {
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
    } slv_t;

    exp_t exp_q[$];
    slv_t slv_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a transfer times out when the slave stalls for TO or more ACCESS cycles.
    function automatic exp_t model(input logic w, input logic [AW-1:0] a,
                                   input logic [DW-1:0] wd, input slv_t s);
        exp_t e;
        e.write = w;
        e.addr  = a;
        e.wdata = wd;
        if (s.waits >= TO) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.acc   = TO;
        end else begin
            e.rdata = w ? '0 : s.prdata;
            e.err   = s.slverr;
            e.acc   = s.waits + 1;
        end
        return e;
    endfunction

    // Present a command (cmd_valid stays high afterwards) and wait for acceptance.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input logic se,
                         output longint t_acc);
        slv_t s;
        t_acc = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (cmd_ready) begin
                s.waits  = waits;
                s.prdata = rd;
                s.slverr = se;
                slv_q.push_back(s);
                exp_q.push_back(model(w, a, wd, s));
                @(posedge clk);
                t_acc = $time;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: cmd_ready never high, expected within 200 cycles");
    endtask

    task automatic idle_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = DW'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    endtask

    // Behavioural slave: stalls 'waits' ACCESS cycles, drives noise everywhere else.
    slv_t cur;
    int   acc_cnt;
    initial begin
        cur.waits = 0; cur.prdata = '0; cur.slverr = 1'b0;
        acc_cnt = 0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
    end
    always @(negedge clk) begin
        if (!reset && psel && !penable) begin
            if (slv_q.size() > 0) cur = slv_q.pop_front();
            acc_cnt = 0;
            pready  = 1'($urandom);
            prdata  = DW'($urandom);
            pslverr = 1'($urandom);
        end else if (!reset && psel && penable) begin
            if (acc_cnt == cur.waits) begin
                pready  = 1'b1;
                prdata  = cur.prdata;
                pslverr = cur.slverr;
            end else begin
                pready  = 1'b0;
                prdata  = DW'($urandom);
                pslverr = 1'($urandom);
            end
            acc_cnt++;
        end else begin
            pready  = 1'($urandom);
            prdata  = DW'($urandom);
            pslverr = 1'($urandom);
        end
    end

    // Monitor: APB signal stability, per-transfer cycle counts, response scoreboard.
    int            psel_cnt = 0;
    int            pen_cnt = 0;
    logic          prev_rv = 1'b0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    exp_t          e_mon;
    always @(negedge clk) begin
        if (reset) begin
            psel_cnt   = 0;
            pen_cnt    = 0;
            prev_rv    = 1'b0;
            last_rdata = '0;
            last_err   = 1'b0;
        end else begin
            if (psel) begin
                psel_cnt++;
                if (penable) pen_cnt++;
                if (exp_q.size() > 0) begin
                    chk("paddr", 64'(paddr), 64'(exp_q[0].addr));
                    chk("pwrite", 64'(pwrite), 64'(exp_q[0].write));
                    chk("pwdata", 64'(pwdata), 64'(exp_q[0].wdata));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL psel_no_cmd: psel=1 expected 0 with no command");
                end
            end
            if (rsp_valid) begin
                chk("rsp_single_pulse", 64'(prev_rv), 64'(0));
                chk("ready_with_rsp", 64'(cmd_ready), 64'(1));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 expected 0");
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_mon.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e_mon.err));
                    chk("penable_cycles", 64'(pen_cnt), 64'(e_mon.acc));
                    chk("psel_cycles", 64'(psel_cnt), 64'(e_mon.acc + 1));
                    last_rdata = e_mon.rdata;
                    last_err   = e_mon.err;
                end
                psel_cnt = 0;
                pen_cnt  = 0;
            end else begin
                chk("rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
                chk("err_hold", 64'(rsp_err), 64'(last_err));
            end
            prev_rv = rsp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    longint t1, t2, td;
    int     w, r;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_psel", 64'(psel), 64'(0));
        chk("rst_penable", 64'(penable), 64'(0));
        chk("rst_pwrite", 64'(pwrite), 64'(0));
        chk("rst_paddr", 64'(paddr), 64'(0));
        chk("rst_pwdata", 64'(pwdata), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        // Zero-wait write, stalled read, slave error, timeout boundaries.
        issue(1'b1, 32'd1, 8'd25, 0, 8'h00, 1'b0, td); idle_cmd(); drain();
        issue(1'b0, 32'd0, 8'h00, 3, 8'h04, 1'b0, td); idle_cmd(); drain();
        issue(1'b0, 32'd3, 8'h11, 0, 8'h9c, 1'b1, td); idle_cmd(); drain();
        issue(1'b0, 32'd7, 8'h22, 100, 8'h5a, 1'b0, td); idle_cmd(); drain();
        issue(1'b0, 32'd8, 8'h33, 15, 8'h6b, 1'b0, td); idle_cmd(); drain();
        issue(1'b1, 32'd9, 8'h44, 16, 8'h7c, 1'b1, td); idle_cmd(); drain();

        // Back-to-back writes with cmd_valid held.
        issue(1'b1, 32'd1, 8'hA1, 0, 8'h00, 1'b0, t1);
        issue(1'b1, 32'd0, 8'hA2, 0, 8'h00, 1'b0, t2);
        idle_cmd(); drain();
        chk("b2b_accept_spacing", 64'((t2 - t1) / 10), 64'(3));

        // Reset in the middle of ACCESS aborts the transfer silently.
        issue(1'b0, 32'h55, 8'h00, 10, 8'h12, 1'b0, td);
        idle_cmd();
        for (int i = 0; i < 10; i++) begin
            if (penable) break;
            @(negedge clk);
        end
        chk("reached_access", 64'(penable), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_psel", 64'(psel), 64'(0));
        chk("rst_mid_penable", 64'(penable), 64'(0));
        exp_q.delete();
        slv_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_abort", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("no_rsp_after_abort", 64'(rsp_valid), 64'(0));
        end
        issue(1'b0, 32'h56, 8'h00, 1, 8'h3e, 1'b0, td); idle_cmd(); drain();

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      w = r % 4;
            else if (r < 9) w = $urandom_range(14, 17);
            else            w = 40;
            issue(1'($urandom), $urandom, DW'($urandom), w, DW'($urandom), 1'($urandom), td);
            if ($urandom_range(0, 2) == 0) begin
                idle_cmd();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        idle_cmd();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter addrWidth, default 32, APB address width.
REQ-002 SHALL have parameter dataWidth, default 8, APB data width.
REQ-003 SHALL have parameter timeoutCycles, default 16, max ACCESS cycles before forced error; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  request present.
REQ-007 SHALL have port cmd_ready  output  1  request accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  input  addrWidth  target address.
REQ-010 SHALL have port cmd_wdata  input  dataWidth  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  dataWidth  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  slave error or timeout, valid with rsp_valid.
REQ-014 SHALL have ports paddr (addrWidth), psel, penable, pwrite (1), pwdata (dataWidth) as outputs and prdata (dataWidth), pready, pslverr (1) as inputs, APB-compliant.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 SHALL drive cmd_ready=1 only in IDLE.
REQ-017 SHALL, on cmd_valid&&cmd_ready, register cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata and enter SETUP next cycle.
REQ-018 SHALL drive psel=1, penable=0 in SETUP for exactly one cycle, then enter ACCESS.
REQ-019 SHALL drive psel=1, penable=1 in ACCESS and hold paddr/pwrite/pwdata stable from SETUP until ACCESS exits.
REQ-020 SHALL, in ACCESS with pready=1, capture prdata (reads only, else 0) and pslverr, return to IDLE, pulse rsp_valid for one cycle on the following cycle.
REQ-021 SHALL count ACCESS cycles with pready=0; on reaching timeoutCycles (when nonzero), exit to IDLE, rsp_err=1, rsp_rdata=0.
REQ-022 SHALL give pready priority over timeout when both occur in the same cycle.
REQ-023 SHALL allow a new command to be accepted in the same cycle rsp_valid is high (back-to-back: 3 cycles per zero-wait transfer).
REQ-024 SHALL ignore prdata/pready/pslverr outside ACCESS.
REQ-025 SHALL hold rsp_rdata/rsp_err unchanged until the next rsp_valid.
REQ-026 SHALL saturate the timeout counter width at clog2(timeoutCycles+1) bits; no wrap.

Reset
REQ-027 SHALL, on reset high, immediately force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-028 SHALL, on reset mid-transfer, abort without response; cmd_ready=1 the first cycle after reset release.

Structure
REQ-029 SHALL place the state enum (IDLE/SETUP/ACCESS) and e_rw (READ/WRITE) in shared package apb_pkg.
REQ-030 SHALL implement the timeout counter as sub-module apb_timeout_ctr (clear, enable, expired output).

Verification
REQ-031 SHALL verify: write addr 1 data 25 to timer, pready=1 immediately -> psel 2 cycles, penable 1 cycle, rsp_valid 1 cycle, rsp_err=0.
REQ-032 SHALL verify: read addr 0 with slave prdata=0x04, 3 wait states -> ACCESS 4 cycles, rsp_rdata=0x04, rsp_err=0.
REQ-033 SHALL verify: read addr 3 with pslverr=1 at pready -> rsp_err=1, rsp_valid pulse.
REQ-034 SHALL verify: pready held 0, timeoutCycles=16 -> exit after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-035 SHALL verify: cmd_valid held high for 2 writes -> second SETUP starts the cycle after first rsp_valid; addresses 1 then 0 in order.
REQ-036 SHALL verify: reset asserted during ACCESS -> psel/penable low same cycle, no rsp_valid, next command completes normally.
